// File: rtl/le_cfg_pkg.sv
// Shared constants, encodings and state type for the LE configuration loader.
package le_cfg_pkg;

  localparam int FRAME_W = 15;
  localparam int FUNC_W  = 3;
  localparam int SEL_W   = 6;

  // Logic-element function encodings carried in the func field of each frame.
  typedef enum logic [FUNC_W-1:0] {
    FN_AND  = 3'd0,
    FN_OR   = 3'd1,
    FN_NOT  = 3'd2,
    FN_XOR  = 3'd3,
    FN_XNOR = 3'd4,
    FN_NAND = 3'd5,
    FN_NOR  = 3'd6,
    FN_BUF  = 3'd7
  } le_func_e;

  // Loader control states.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_CHECK,
    ST_COMMIT,
    ST_ERROR
  } cfg_state_e;

  // True when a selector points past the last legal LE input.
  function automatic logic sel_out_of_range(input logic [SEL_W-1:0] sel, input int num_in);
    return int'(sel) >= num_in;
  endfunction

endpackage

// File: rtl/le_cfg_shadow.sv
// Serial shadow register for the LE configuration stream. Bits arrive LSB
// first, LE 0 first, and enter at the top of the register so that after all
// frames have arrived frame k sits at [15k+14:15k]. A frame-position counter
// spots the last bit of each frame so the selectors can be range-checked
// while that frame is still at the top of the register.
module le_cfg_shadow
  import le_cfg_pkg::*;
#(
  parameter int NUM_LE = 8,
  parameter int NUM_IN = 33
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear_i,
  input  logic                      shift_i,
  input  logic                      bit_i,
  output logic [NUM_LE*FRAME_W-1:0] shadow_o,
  output logic                      range_err_o
);

  localparam int SHADOW_W = NUM_LE * FRAME_W;
  // Bit index where the frame currently completing starts (its top bit is bit_i).
  localparam int FRAME_BASE = SHADOW_W - (FRAME_W - 1);
  localparam logic [3:0] LAST_POS = 4'(FRAME_W - 1);

  logic [SHADOW_W-1:0] shadow_q, shadow_d;
  logic [3:0]          pos_q, pos_d;
  logic                range_q, range_d;
  logic [SEL_W-1:0]    sel_a, sel_b;

  // Shift in accepted data bits and range-check each frame as it completes.
  always_comb begin
    shadow_d = shadow_q;
    pos_d    = pos_q;
    range_d  = range_q;
    sel_a    = shadow_q[FRAME_BASE+FUNC_W +: SEL_W];
    sel_b    = {bit_i, shadow_q[FRAME_BASE+FUNC_W+SEL_W +: SEL_W-1]};
    if (clear_i) begin
      shadow_d = '0;
      pos_d    = '0;
      range_d  = 1'b0;
    end else if (shift_i) begin
      shadow_d = {bit_i, shadow_q[SHADOW_W-1:1]};
      if (pos_q == LAST_POS) begin
        pos_d = '0;
        if (sel_out_of_range(sel_a, NUM_IN) || sel_out_of_range(sel_b, NUM_IN)) begin
          range_d = 1'b1;
        end
      end else begin
        pos_d = pos_q + 4'd1;
      end
    end
  end

  // Shadow state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q <= '0;
      pos_q    <= '0;
      range_q  <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      pos_q    <= pos_d;
      range_q  <= range_d;
    end
  end

  assign shadow_o    = shadow_q;
  assign range_err_o = range_q;

endmodule

// File: rtl/le_config_loader.sv
// Serial configuration loader for a bank of logic elements. A load is
// NUM_LE 15-bit frames plus one even-parity bit. The stream is collected in a
// shadow register and only copied to the active outputs when the parity and
// selector range checks both pass, so a bad load never disturbs the running
// configuration.
module le_config_loader
  import le_cfg_pkg::*;
#(
  parameter int NUM_LE = 8,
  parameter int NUM_IN = 33
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cfg_start,
  input  logic                        cfg_bit,
  input  logic                        cfg_valid,
  output logic                        cfg_ready,
  output logic                        busy,
  output logic                        cfg_done,
  output logic                        cfg_err,
  output logic [FUNC_W*NUM_LE-1:0]    le_func,
  output logic [2*SEL_W*NUM_LE-1:0]   le_ins
);

  localparam int DATA_BITS = NUM_LE * FRAME_W;
  localparam int CNT_W     = $clog2(NUM_LE * FRAME_W + 2);
  localparam logic [CNT_W-1:0] PARITY_IDX = CNT_W'(DATA_BITS);

  cfg_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic parity_q, parity_d;
  logic [FUNC_W*NUM_LE-1:0]  func_q, func_d;
  logic [2*SEL_W*NUM_LE-1:0] ins_q, ins_d;

  logic                 shadow_clear;
  logic                 shadow_shift;
  logic [DATA_BITS-1:0] shadow;
  logic                 range_err;
  logic [FUNC_W*NUM_LE-1:0]  func_load;
  logic [2*SEL_W*NUM_LE-1:0] ins_load;

  le_cfg_shadow #(
    .NUM_LE (NUM_LE),
    .NUM_IN (NUM_IN)
  ) u_shadow (
    .clk         (clk),
    .rst         (rst),
    .clear_i     (shadow_clear),
    .shift_i     (shadow_shift),
    .bit_i       (cfg_bit),
    .shadow_o    (shadow),
    .range_err_o (range_err)
  );

  // Unpack each frame: func in the low 3 bits, then sel_a and sel_b which
  // already sit side by side in the order the active bus wants them.
  for (genvar k = 0; k < NUM_LE; k++) begin : g_unpack
    assign func_load[k*FUNC_W +: FUNC_W]  = shadow[k*FRAME_W +: FUNC_W];
    assign ins_load[k*2*SEL_W +: 2*SEL_W] = shadow[k*FRAME_W+FUNC_W +: 2*SEL_W];
  end

  // Next-state logic: bit acceptance, parity accumulation, check and commit.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    parity_d     = parity_q;
    func_d       = func_q;
    ins_d        = ins_q;
    shadow_clear = 1'b0;
    shadow_shift = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cfg_start) begin
          state_d      = ST_SHIFT;
          cnt_d        = '0;
          parity_d     = 1'b0;
          shadow_clear = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (cfg_start) begin
          cnt_d        = '0;
          parity_d     = 1'b0;
          shadow_clear = 1'b1;
        end else if (cfg_valid) begin
          parity_d = parity_q ^ cfg_bit;
          cnt_d    = cnt_q + CNT_W'(1);
          if (cnt_q == PARITY_IDX) begin
            state_d = ST_CHECK;
          end else begin
            shadow_shift = 1'b1;
          end
        end
      end
      ST_CHECK: begin
        state_d = (!parity_q && !range_err) ? ST_COMMIT : ST_ERROR;
      end
      ST_COMMIT: begin
        func_d  = func_load;
        ins_d   = ins_load;
        state_d = ST_IDLE;
      end
      ST_ERROR: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counter, parity and active configuration registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      parity_q <= 1'b0;
      func_q   <= '0;
      ins_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      parity_q <= parity_d;
      func_q   <= func_d;
      ins_q    <= ins_d;
    end
  end

  // Status outputs are masked by rst so a reset landing on the COMMIT cycle
  // never shows a done pulse for a commit that will not happen.
  assign cfg_ready = (state_q == ST_SHIFT)  && !rst;
  assign busy      = (state_q != ST_IDLE)   && !rst;
  assign cfg_done  = (state_q == ST_COMMIT) && !rst;
  assign cfg_err   = (state_q == ST_ERROR)  && !rst;
  assign le_func   = func_q;
  assign le_ins    = ins_q;

endmodule

// File: tb/tb_le_config_loader.sv
// Bench for le_config_loader: table of load vectors plus hand-written
// abort and reset-in-commit sequences, checked through a scoreboard queue.
module tb_le_config_loader;

   localparam int NUM_LE     = 8;
   localparam int NUM_IN     = 33;
   localparam int DATA_BITS  = NUM_LE * 15;
   localparam int TOTAL_BITS = DATA_BITS + 1;
   localparam int NUM_VECS   = 6;

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic cfgStart = 1'b0;
   logic cfgBit = 1'b0;
   logic cfgValid = 1'b0;
   logic cfgReady, busy, cfgDone, cfgErr;
   logic [NUM_LE*3-1:0]  leFunc;
   logic [NUM_LE*12-1:0] leIns;

   typedef struct {
      logic [DATA_BITS-1:0] frames;
      bit badParity;
      bit randValid;
      bit startInCheck;
      bit expOk;
   } vec_t;

   typedef struct {
      bit ok;
      logic [NUM_LE*3-1:0]  func;
      logic [NUM_LE*12-1:0] ins;
   } exp_t;

   exp_t expQ[$];
   vec_t vecs[NUM_VECS];

   int testsRun = 0;
   int testsFailed = 0;

   logic [NUM_LE*3-1:0]  lastFunc = '0;
   logic [NUM_LE*12-1:0] lastIns = '0;
   logic [NUM_LE*3-1:0]  heldFunc = '0;
   logic [NUM_LE*12-1:0] heldIns = '0;
   logic [NUM_LE*3-1:0]  pendFunc = '0;
   logic [NUM_LE*12-1:0] pendIns = '0;
   bit checkCfgPending = 1'b0;

   // Free-running clock.
   always #5 clock = ~clock;

   le_config_loader #(
      .NUM_LE (NUM_LE),
      .NUM_IN (NUM_IN)
   ) dut (
      .clk       (clock),
      .rst       (reset),
      .cfg_start (cfgStart),
      .cfg_bit   (cfgBit),
      .cfg_valid (cfgValid),
      .cfg_ready (cfgReady),
      .busy      (busy),
      .cfg_done  (cfgDone),
      .cfg_err   (cfgErr),
      .le_func   (leFunc),
      .le_ins    (leIns)
   );

   // Single comparison point; every check in the bench goes through here.
   task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
      testsRun++;
      if (act !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [14:0] mkFrame(input int f, input int a, input int b);
      return {6'(b), 6'(a), 3'(f)};
   endfunction

   function automatic logic [NUM_LE*3-1:0] modelFunc(input logic [DATA_BITS-1:0] fr);
      logic [NUM_LE*3-1:0] r;
      r = '0;
      for (int k = 0; k < NUM_LE; k++) r[k*3 +: 3] = fr[k*15 +: 3];
      return r;
   endfunction

   function automatic logic [NUM_LE*12-1:0] modelIns(input logic [DATA_BITS-1:0] fr);
      logic [NUM_LE*12-1:0] r;
      r = '0;
      for (int k = 0; k < NUM_LE; k++) begin
         r[k*12 +: 6]     = fr[k*15+3 +: 6];
         r[k*12+6 +: 6]   = fr[k*15+9 +: 6];
      end
      return r;
   endfunction

   // Scoreboard side: pop on every done/err pulse, check the active
   // configuration on the following cycle once the commit edge has passed.
   always @(negedge clock) begin
      exp_t e;
      if (checkCfgPending) begin
         checkOutput("activeFunc", 128'(leFunc), 128'(pendFunc));
         checkOutput("activeIns", 128'(leIns), 128'(pendIns));
         checkCfgPending = 1'b0;
      end
      if (cfgDone || cfgErr) begin
         checkOutput("doneErrExclusive", 128'(cfgDone & cfgErr), 128'(0));
         checkOutput("pulseExpected", 128'(expQ.size() != 0), 128'(1));
         if (expQ.size() != 0) begin
            e = expQ.pop_front();
            checkOutput("doneFlag", 128'(cfgDone), 128'(e.ok));
            checkOutput("errFlag", 128'(cfgErr), 128'(!e.ok));
            pendFunc = e.func;
            pendIns = e.ins;
            checkCfgPending = 1'b1;
         end
      end
   end

   // Drive a start pulse (with a stray valid bit that must be ignored) and
   // then nBits stream bits; a full stream also covers the CHECK cycle.
   task automatic driveBits(input logic [DATA_BITS-1:0] fr, input bit bad, input bit rv,
                            input int nBits, input bit poke, input bit stopInCheck,
                            output int acc);
      logic par;
      par = ^fr;
      if (bad) par = ~par;
      acc = 0;
      cfgStart = 1'b1;
      cfgValid = 1'b1;
      cfgBit = 1'b1;
      @(negedge clock);
      cfgStart = 1'b0;
      cfgValid = 1'b0;
      for (int i = 0; i < nBits; i++) begin
         if (rv) begin
            for (int s = 0; s < 8 && $urandom_range(1, 0) == 0; s++) begin
               cfgValid = 1'b0;
               @(negedge clock);
            end
         end
         if (i == DATA_BITS) begin
            checkOutput("heldFuncDuringShift", 128'(leFunc), 128'(heldFunc));
            checkOutput("heldInsDuringShift", 128'(leIns), 128'(heldIns));
         end
         cfgValid = 1'b1;
         cfgBit = (i < DATA_BITS) ? fr[i] : par;
         #1;
         if (cfgReady) acc++;
         @(negedge clock);
      end
      cfgValid = 1'b0;
      if (nBits == TOTAL_BITS) begin
         cfgValid = 1'b1;
         cfgBit = 1'b1;
         if (poke) cfgStart = 1'b1;
         #1;
         checkOutput("readyLowAfterParity", 128'(cfgReady), 128'(0));
         checkOutput("busyInCheck", 128'(busy), 128'(1));
         if (!stopInCheck) begin
            @(negedge clock);
            cfgValid = 1'b0;
            cfgStart = 1'b0;
         end
      end
   endtask

   // Bounded wait for the scoreboard to empty.
   task automatic waitDrained();
      for (int c = 0; c < 12; c++) begin
         if (expQ.size() == 0 && !checkCfgPending) break;
         @(negedge clock);
      end
      if (expQ.size() != 0 || checkCfgPending) begin
         checkOutput("scoreboardDrained", 128'(expQ.size() != 0 || checkCfgPending), 128'(0));
         expQ.delete();
         checkCfgPending = 1'b0;
      end
   endtask

   // One table-driven load: predict, push, drive, wait for the outcome.
   task automatic applyStimulus(input vec_t v);
      exp_t e;
      int acc;
      heldFunc = lastFunc;
      heldIns = lastIns;
      e.ok = v.expOk;
      e.func = v.expOk ? modelFunc(v.frames) : lastFunc;
      e.ins = v.expOk ? modelIns(v.frames) : lastIns;
      lastFunc = e.func;
      lastIns = e.ins;
      expQ.push_back(e);
      driveBits(v.frames, v.badParity, v.randValid, TOTAL_BITS, v.startInCheck, 1'b0, acc);
      checkOutput("bitsAccepted", 128'(acc), 128'(TOTAL_BITS));
      waitDrained();
      checkOutput("idleAfterLoad", 128'(busy), 128'(0));
   endtask

   initial begin
      int acc;
      logic [DATA_BITS-1:0] junk;

      // Vector table.
      for (int i = 0; i < NUM_VECS; i++) begin
         vecs[i].frames = '0;
         vecs[i].badParity = 1'b0;
         vecs[i].randValid = 1'b0;
         vecs[i].startInCheck = 1'b0;
         vecs[i].expOk = 1'b1;
      end
      vecs[0].frames[14:0] = mkFrame(3, 5, 32);
      vecs[1] = vecs[0];
      vecs[1].badParity = 1'b1;
      vecs[1].expOk = 1'b0;
      vecs[2].frames[7*15 +: 15] = mkFrame(0, 0, 33);
      vecs[2].expOk = 1'b0;
      for (int k = 0; k < NUM_LE; k++) vecs[3].frames[k*15 +: 15] = mkFrame(k, 4 * k, 32 - k);
      vecs[3].randValid = 1'b1;
      vecs[4] = vecs[3];
      vecs[4].frames[3*15 +: 15] = mkFrame(3, 63, 1);
      vecs[4].randValid = 1'b0;
      vecs[4].expOk = 1'b0;
      vecs[5] = vecs[0];
      vecs[5].randValid = 1'b1;
      vecs[5].startInCheck = 1'b1;

      // Reset state.
      repeat (2) @(negedge clock);
      checkOutput("resetReady", 128'(cfgReady), 128'(0));
      checkOutput("resetBusy", 128'(busy), 128'(0));
      checkOutput("resetDone", 128'(cfgDone), 128'(0));
      checkOutput("resetErr", 128'(cfgErr), 128'(0));
      checkOutput("resetFunc", 128'(leFunc), 128'(0));
      checkOutput("resetIns", 128'(leIns), 128'(0));
      reset = 1'b0;
      @(negedge clock);

      for (int i = 0; i < NUM_VECS; i++) begin
         applyStimulus(vecs[i]);
         if (i == 0) begin
            checkOutput("le0Func", 128'(leFunc[2:0]), 128'(3));
            checkOutput("le0Ins", 128'(leIns[11:0]), 128'(12'h805));
         end
      end

      // Abort after 40 bits of a junk stream, then a full legal load.
      for (int k = 0; k < NUM_LE; k++) junk[k*15 +: 15] = 15'($urandom);
      heldFunc = lastFunc;
      heldIns = lastIns;
      driveBits(junk, 1'b0, 1'b0, 40, 1'b0, 1'b0, acc);
      checkOutput("partialBitsAccepted", 128'(acc), 128'(40));
      checkOutput("activeHeldAfterPartial", 128'(leFunc), 128'(lastFunc));
      applyStimulus(vecs[3]);

      // Reset landing on the COMMIT cycle.
      heldFunc = lastFunc;
      heldIns = lastIns;
      driveBits(vecs[0].frames, 1'b0, 1'b0, TOTAL_BITS, 1'b0, 1'b1, acc);
      @(posedge clock);
      #1;
      reset = 1'b1;
      cfgValid = 1'b0;
      cfgStart = 1'b0;
      @(negedge clock);
      checkOutput("doneMaskedByReset", 128'(cfgDone), 128'(0));
      @(posedge clock);
      #1;
      reset = 1'b0;
      @(negedge clock);
      checkOutput("postResetFunc", 128'(leFunc), 128'(0));
      checkOutput("postResetIns", 128'(leIns), 128'(0));
      checkOutput("postResetBusy", 128'(busy), 128'(0));
      checkOutput("postResetDone", 128'(cfgDone), 128'(0));
      checkOutput("postResetReady", 128'(cfgReady), 128'(0));
      lastFunc = '0;
      lastIns = '0;
      repeat (3) @(negedge clock);
      checkOutput("noStrayExpectations", 128'(expQ.size()), 128'(0));

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/le_config_loader.md
LE_CONFIG_LOADER -- requirements
Module: le_config_loader

Interface
REQ-001 SHALL have parameter NUM_LE, default 8: number of logic elements configured.
REQ-002 SHALL have parameter NUM_IN, default 33: width of the LE input bus; legal selector values are 0..NUM_IN-1.
REQ-003 SHALL have one clock and a synchronous, active-high reset: clk  in  1  rising-edge clock.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 cfg_start  in  1  one-cycle pulse that begins a load.
REQ-006 cfg_bit  in  1  serial configuration data.
REQ-007 cfg_valid  in  1  cfg_bit is valid this cycle.
REQ-008 cfg_ready  out  1  loader accepts a bit this cycle.
REQ-009 busy  out  1  a load is in progress (any state other than IDLE).
REQ-010 cfg_done  out  1  one-cycle pulse: new configuration committed.
REQ-011 cfg_err  out  1  one-cycle pulse: load rejected.
REQ-012 le_func  out  3*NUM_LE  active function select per LE; LE k occupies bits [3k+2:3k].
REQ-013 le_ins  out  12*NUM_LE  active input selectors per LE; LE k occupies [12k+11:12k], with sel_a in the low 6 bits and sel_b in the high 6 bits.

Function
REQ-014 SHALL implement states IDLE, SHIFT, CHECK, COMMIT and ERROR.
REQ-015 IDLE: on cfg_start go to SHIFT, clear the bit counter, clear the parity accumulator and clear the range-error flag.
REQ-016 SHIFT: cfg_ready=1; a bit is accepted on a clock edge where cfg_valid and cfg_ready are both 1; at most one bit is accepted per cycle.
REQ-017 The stream SHALL be NUM_LE 15-bit frames followed by one even-parity bit, for NUM_LE*15+1 bits in total; LE 0 comes first, and each frame is sent LSB first.
REQ-018 Frame bit layout: [2:0] func, [8:3] sel_a, [14:9] sel_b.
REQ-019 Frames SHALL shift into a shadow register; the active outputs SHALL NOT change during SHIFT.
REQ-020 As each frame completes, the range-error flag SHALL be set if sel_a or sel_b is greater than or equal to NUM_IN.
REQ-021 Acceptance of the final (parity) bit -> CHECK; cfg_ready=0 from the next cycle.
REQ-022 CHECK lasts exactly one cycle; it goes to COMMIT if the XOR over all accepted bits is 0 and the range-error flag is clear, otherwise to ERROR.
REQ-023 COMMIT: load the shadow into le_func/le_ins on the edge leaving COMMIT; cfg_done=1 for that one cycle; then go to IDLE.
REQ-024 ERROR: cfg_err=1 for one cycle; the active configuration is left unchanged; then go to IDLE.
REQ-025 Latency: the active outputs change on the 2nd rising edge after the edge that accepted the parity bit.
REQ-026 cfg_start during SHIFT SHALL abort and restart the load: counter, parity and flag are cleared, the partial shadow is discarded, and any cfg_valid bit in that same cycle is not accepted.
REQ-027 cfg_start in CHECK, COMMIT or ERROR SHALL be ignored.
REQ-028 cfg_valid outside SHIFT SHALL be ignored.
REQ-029 cfg_valid low in SHIFT stalls the load indefinitely; there is no timeout.
REQ-030 cfg_done and cfg_err SHALL never be asserted in the same cycle.
REQ-031 The bit counter width SHALL be $clog2(NUM_LE*15+2); the counter SHALL NOT wrap within a load.

Reset
REQ-032 rst SHALL force state IDLE and cfg_ready=0, busy=0, cfg_done=0, cfg_err=0, le_func=0, le_ins=0, shadow=0, counter=0, parity=0 and range-error flag=0.
REQ-033 rst SHALL take priority over every other input, including mid-load and in the COMMIT cycle; a commit in progress SHALL NOT occur.

Structure
REQ-034 Package le_cfg_pkg SHALL hold FRAME_W=15, FUNC_W=3, SEL_W=6, the function encodings (AND=0, OR=1, NOT=2, XOR=3, XNOR=4, NAND=5, NOR=6, BUF=7) and the state enum.
REQ-035 Sub-module le_cfg_shadow SHALL hold the serial shadow shift register and the per-frame selector range check; the FSM, parity and active registers SHALL be in the top module.

Verification
REQ-036 Reset, then a legal load of 121 bits with LE0={func=3, sel_a=5, sel_b=32} and all other LEs 0, correct parity -> cfg_done pulses once 2 edges after the parity bit; le_func[2:0]=3, le_ins[11:0]=0x805.
REQ-037 The same load with the parity bit inverted -> cfg_err pulses; le_func/le_ins keep their previous values; cfg_done stays 0.
REQ-038 A load with LE7 sel_b=33 and correct parity -> cfg_err; no change to the active configuration.
REQ-039 cfg_start reasserted after 40 bits, then a full legal load -> exactly one cfg_done, with outputs matching the second stream only.
REQ-040 cfg_valid toggled randomly during SHIFT (50% duty) -> same result as the back-to-back load; 121 bits accepted; cfg_ready=0 outside SHIFT.
REQ-041 rst asserted in the COMMIT cycle -> no cfg_done; all outputs 0 on the next cycle; busy=0.
